// File: rtl/alu_uart_interface.sv
// Byte-serial front/back end for the ALU: gathers A, B and opcode from a UART receiver,
// presents them to the ALU and hands the one-byte result to a UART transmitter.
module alu_uart_interface #(
    parameter int BUS_LEN = 8,
    parameter int OP_LEN  = 6,
    parameter int TIMEOUT = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_done,
    input  logic               tx_done,
    input  logic [BUS_LEN-1:0] alu_out,
    output logic [BUS_LEN-1:0] A,
    output logic [BUS_LEN-1:0] B,
    output logic [OP_LEN-1:0]  opcode,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    output logic               busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t              state_q;
    logic [BUS_LEN-1:0]  a_q, b_q;
    logic [OP_LEN-1:0]   op_q;
    logic [7:0]          tx_data_q;
    logic                tx_start_q;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic                expired;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));
    assign cnt_d   = cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    cnt_q <= '0;
                    if (rx_done) begin
                        a_q     <= rx_data[BUS_LEN-1:0];
                        state_q <= WAIT_B;
                    end
                end
                // A byte arriving on the expiry cycle wins over the abort.
                WAIT_B: begin
                    if (rx_done) begin
                        b_q     <= rx_data[BUS_LEN-1:0];
                        state_q <= WAIT_OP;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q <= WAIT_A;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                WAIT_OP: begin
                    if (rx_done) begin
                        op_q    <= rx_data[OP_LEN-1:0];
                        state_q <= EXEC;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q <= WAIT_A;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                // ALU inputs became stable at the previous edge; sample its result now.
                EXEC: begin
                    tx_data_q  <= 8'(alu_out);
                    tx_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= WAIT_TX;
                end
                WAIT_TX: begin
                    cnt_q <= '0;
                    if (tx_done) state_q <= WAIT_A;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign opcode   = op_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q != WAIT_A);

endmodule
